cook_timer: RTL and testbench
=============================

Name: cook_timer

Overview:
- Countdown cook timer for the microwave. Produces the `timer_done` signal that the magnetron control logic consumes.
- Loads a 4-digit BCD MM:SS value from keypad digit strobes.
- Counts down one second per prescaled tick while the magnetron latch output (`magnetron_on`) is high.
- Pauses when the magnetron drops. Asserts `timer_done` when the count reaches 00:00.

Parameters:
- TICK_DIV, 50000000: clock cycles per 1-second tick. Must be ≥2; benches use 4.
- PW, 26: prescaler width. Must satisfy 2^PW ≥ TICK_DIV.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- clearn  in  1  synchronous clear, active-low. Level sampled every cycle.
- digit  in  4  keypad BCD digit.
- digit_valid  in  1  one-cycle strobe qualifying `digit`.
- magnetron_on  in  1  magnetron latch output; 1 = magnetron running.
- min_tens, min_ones, sec_tens, sec_ones  out  4 each  registered BCD count.
- timer_done  out  1  registered; 1 = cook time elapsed.
- state  out  2  registered FSM state: IDLE=0, RUN=1, PAUSE=2, DONE=3.

Behaviour:
- Reset (resetn=0, async):
  - All four digits = 0.
  - timer_done = 0.
  - state = IDLE.
  - Prescaler = 0.
  - Outputs take these values immediately on reset assertion.
- clearn=0 (sync): same values as reset, applied on the next edge, from any state. It has priority over every other input in that cycle.
- count==0 means all four digits are 0.
- Digit entry:
  - Accepted only in IDLE or DONE, with digit_valid=1 and digit ≤9.
  - Shift-left load: min_tens←min_ones, min_ones←sec_tens, sec_tens←sec_ones, sec_ones←digit.
  - In DONE, the digits are first treated as 0000, so the result is 000d. State goes to IDLE and timer_done goes to 0 on that edge.
  - Digits >9, and digits entered in RUN or PAUSE, are ignored with no state change.
  - Prescaler is reset to 0 on every accepted digit.
- sec_tens >5 is accepted as entered (e.g. 00:99). It decrements normally; after a borrow out of sec_tens it reloads to 5.
- FSM transitions (evaluated only when clearn=1):
  - IDLE:
    - magnetron_on=1 and count≠0 → RUN.
    - magnetron_on=1 and count==0 → DONE, timer_done←1 (zero-time cook aborted).
    - Digit entry takes precedence over magnetron_on in the same cycle: load the digit, stay IDLE.
  - RUN:
    - magnetron_on=1: prescaler increments each edge.
    - When prescaler==TICK_DIV-1: prescaler←0 and count decrements one second.
    - If the pre-decrement count is 00:01: count←00:00, state←DONE, timer_done←1, all on the same edge.
    - magnetron_on=0 → PAUSE. No decrement that cycle even if the prescaler is at terminal. Prescaler holds its value.
  - PAUSE:
    - Count and prescaler hold.
    - magnetron_on=1 → RUN. Ticking resumes from the held prescaler value.
  - DONE:
    - timer_done=1, count=0000.
    - Ignores magnetron_on.
    - Exits only via clearn, resetn, or a valid digit.
- BCD decrement (one second):
  - sec_ones 0→9, borrow.
  - sec_tens 0→5, borrow.
  - min_ones 0→9, borrow.
  - min_tens decrements.
  - Decrement is never applied at count==0. Count never wraps past 00:00.
- Timing:
  - Entry to RUN costs one edge. Each second then costs TICK_DIV edges.
  - A cook of N seconds with magnetron_on continuously high ends 1+N·TICK_DIV edges after magnetron_on is first sampled high in IDLE.
- timer_done is high only in DONE. It is glitch-free (registered).

Test Plan (TICK_DIV=4):
1. Digit entry:
   - Reset, then strobe digits 1,3,0 → outputs 0,1,3,0 (01:30).
   - Strobe digit=0xA → no change.
   - Strobe 5 → 1,3,0,5 (13:05).
2. Short cook:
   - Enter 5 (00:05), hold magnetron_on=1.
   - state=RUN after edge 1.
   - sec_ones = 4,3,2,1 at edges 5,9,13,17.
   - Edge 21: count 00:00, state=DONE, timer_done=1.
   - timer_done stays 1 while magnetron_on stays 1.
3. Borrows:
   - 01:00 → 00:59 after one tick.
   - 10:00 → 09:59.
   - 00:99 → 00:98 … 00:90 → 00:89.
4. Pause/resume:
   - Load 00:03, run 6 edges (count 00:02, prescaler=1).
   - Drop magnetron_on for 10 cycles → state=PAUSE, count 00:02 unchanged.
   - Reassert → RUN. Next decrement 3 edges after re-entry into RUN.
   - Digit strobes during PAUSE are ignored.
5. Clear and zero start:
   - clearn=0 during RUN at 00:07 → next edge: 00:00, IDLE, timer_done=0.
   - magnetron_on=1 with count 0 in IDLE → DONE, timer_done=1 next edge.
   - Digit 4 then → 00:04, IDLE, timer_done=0.
6. Async reset:
   - Assert resetn=0 mid-RUN between clock edges → outputs 0000, timer_done=0, state=IDLE immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cook_timer.sv
// Microwave countdown timer: keypad-loaded BCD MM:SS that counts down one second
// per prescaled tick while the magnetron runs, flagging timer_done at 00:00.
module cook_timer #(
    parameter int TICK_DIV = 50000000,
    parameter int PW       = 26
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       clearn,
    input  logic [3:0] digit,
    input  logic       digit_valid,
    input  logic       magnetron_on,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       timer_done,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_reg;
    logic [3:0]    cnt_reg [4];   // [0]=sec_ones .. [3]=min_tens
    logic [PW-1:0] presc_reg;
    logic          done_reg;

    logic [3:0] dec_next   [4];
    logic [3:0] shift_next [4];
    logic [3:0] is_zero;
    logic [3:0] borrow;
    logic       count_zero;
    logic       count_one;
    logic       digit_ok;
    logic       tick;

    // Per-digit borrow chain for a one-second decrement, and the keypad shift path.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            localparam logic [3:0] WRAP = (gi == 1) ? 4'd5 : 4'd9;
            assign is_zero[gi] = (cnt_reg[gi] == 4'd0);
            if (gi == 0) begin : g_lsd
                assign borrow[gi]     = 1'b1;
                assign shift_next[gi] = digit;
            end else begin : g_upper
                assign borrow[gi]     = &is_zero[gi-1:0];
                assign shift_next[gi] = cnt_reg[gi-1];
            end
            assign dec_next[gi] = !borrow[gi] ? cnt_reg[gi]
                                : (is_zero[gi] ? WRAP : cnt_reg[gi] - 4'd1);
        end
    endgenerate

    assign count_zero = &is_zero;
    assign count_one  = (cnt_reg[0] == 4'd1) && (&is_zero[3:1]);
    assign digit_ok   = digit_valid && (digit <= 4'd9)
                        && ((state_reg == IDLE) || (state_reg == DONE));
    assign tick       = (presc_reg == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= IDLE;
            done_reg  <= 1'b0;
            presc_reg <= '0;
            for (int i = 0; i < 4; i++) cnt_reg[i] <= 4'd0;
        end else if (!clearn) begin
            state_reg <= IDLE;
            done_reg  <= 1'b0;
            presc_reg <= '0;
            for (int i = 0; i < 4; i++) cnt_reg[i] <= 4'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (digit_ok) begin
                        presc_reg <= '0;
                        for (int i = 0; i < 4; i++) cnt_reg[i] <= shift_next[i];
                    end else if (magnetron_on) begin
                        if (count_zero) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (!magnetron_on) begin
                        state_reg <= PAUSE;
                    end else if (tick) begin
                        presc_reg <= '0;
                        if (!count_zero) begin
                            for (int i = 0; i < 4; i++) cnt_reg[i] <= dec_next[i];
                        end
                        if (count_one || count_zero) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end
                    end else begin
                        presc_reg <= presc_reg + 1'b1;
                    end
                end
                PAUSE: begin
                    if (magnetron_on) state_reg <= RUN;
                end
                DONE: begin
                    // A fresh digit starts a new entry from 000d.
                    if (digit_ok) begin
                        state_reg  <= IDLE;
                        done_reg   <= 1'b0;
                        presc_reg  <= '0;
                        cnt_reg[0] <= digit;
                        cnt_reg[1] <= 4'd0;
                        cnt_reg[2] <= 4'd0;
                        cnt_reg[3] <= 4'd0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign sec_ones   = cnt_reg[0];
    assign sec_tens   = cnt_reg[1];
    assign min_ones   = cnt_reg[2];
    assign min_tens   = cnt_reg[3];
    assign timer_done = done_reg;
    assign state      = state_reg;

endmodule

// File: tb/tb_cook_timer.sv
// Bench for cook_timer: directed scenarios plus random traffic, every cycle
// compared against an arithmetic model of the timer (MMSS kept as a decimal number).
module tb_cook_timer;

    localparam int TICK_DIV = 4;
    localparam int PW       = 3;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       clearn = 1'b1;
    logic [3:0] digit = 4'd0;
    logic       digit_valid = 1'b0;
    logic       magnetron_on = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       timer_done;
    logic [1:0] state;

    cook_timer #(.TICK_DIV(TICK_DIV), .PW(PW)) dut (
        .clk(clk), .resetn(resetn), .clearn(clearn), .digit(digit),
        .digit_valid(digit_valid), .magnetron_on(magnetron_on),
        .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens),
        .sec_ones(sec_ones), .timer_done(timer_done), .state(state)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference: 0=idle 1=run 2=pause 3=done; m_val is MMSS as a decimal number.
    int m_state = 0;
    int m_val   = 0;
    int m_pre   = 0;
    bit m_done  = 1'b0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_pack();
        return {13'd0, 2'(m_state), m_done, 4'(m_val / 1000), 4'((m_val / 100) % 10),
                4'((m_val / 10) % 10), 4'(m_val % 10)};
    endfunction

    function automatic logic [31:0] dut_pack();
        return {13'd0, state, timer_done, min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    function automatic logic [31:0] dut_digits();
        return {16'd0, min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    function automatic int dec_secs(input int v);
        int m, s;
        m = v / 100;
        s = v % 100;
        if (s > 0) s = s - 1;
        else if (m > 0) begin m = m - 1; s = 59; end
        return m * 100 + s;
    endfunction

    task automatic model_reset();
        m_state = 0; m_val = 0; m_pre = 0; m_done = 1'b0;
    endtask

    task automatic model_edge();
        bit key_ok;
        key_ok = digit_valid && (digit <= 4'd9);
        if (!resetn || !clearn) begin
            model_reset();
        end else begin
            case (m_state)
                0: if (key_ok) begin
                       m_val = (m_val * 10 + int'(digit)) % 10000;
                       m_pre = 0;
                   end else if (magnetron_on) begin
                       if (m_val == 0) begin m_state = 3; m_done = 1'b1; end
                       else m_state = 1;
                   end
                1: if (!magnetron_on) m_state = 2;
                   else if (m_pre == TICK_DIV - 1) begin
                       m_pre = 0;
                       m_val = dec_secs(m_val);
                       if (m_val == 0) begin m_state = 3; m_done = 1'b1; end
                   end else m_pre = m_pre + 1;
                2: if (magnetron_on) m_state = 1;
                default: if (key_ok) begin
                       m_val = int'(digit); m_state = 0; m_done = 1'b0; m_pre = 0;
                   end
            endcase
        end
    endtask

    task automatic cyc(input bit dv, input logic [3:0] d, input bit mag, input bit clr);
        digit_valid  = dv;
        digit        = d;
        magnetron_on = mag;
        clearn       = clr;
        @(posedge clk);
        model_edge();
        #1;
        check_value("cycle", dut_pack(), model_pack());
    endtask

    task automatic idle(input bit mag);
        cyc(1'b0, 4'd0, mag, 1'b1);
    endtask

    task automatic key(input logic [3:0] d);
        cyc(1'b1, d, 1'b0, 1'b1);
    endtask

    task automatic clr_cyc();
        cyc(1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    initial begin
        bit mag;
        model_reset();
        #1;
        check_value("reset", dut_pack(), model_pack());
        #12 resetn = 1'b1;

        // Digit entry
        key(4'd1); key(4'd3); key(4'd0);
        check_value("load_0130", dut_digits(), 32'h0130);
        key(4'hA);
        check_value("ignore_hex", dut_digits(), 32'h0130);
        key(4'd5);
        check_value("load_1305", dut_digits(), 32'h1305);

        // Short cook of 5 seconds
        clr_cyc();
        key(4'd5);
        for (int e = 1; e <= 24; e++) begin
            idle(1'b1);
            if (e == 1) check_value("run_entry", 32'(state), 32'd1);
            if (e == 5 || e == 9 || e == 13 || e == 17)
                check_value("tick_ones", 32'(sec_ones), 32'(5 - (e - 1) / 4));
            if (e == 21) check_value("done_edge", dut_pack(), {13'd0, 2'd3, 1'b1, 16'h0000});
            if (e > 21) check_value("done_hold", 32'(timer_done), 32'd1);
        end

        // Borrows
        clr_cyc();
        key(4'd1); key(4'd0); key(4'd0);
        for (int e = 0; e < 5; e++) idle(1'b1);
        check_value("borrow_0100", dut_digits(), 32'h0059);
        clr_cyc();
        key(4'd1); key(4'd0); key(4'd0); key(4'd0);
        for (int e = 0; e < 5; e++) idle(1'b1);
        check_value("borrow_1000", dut_digits(), 32'h0959);
        clr_cyc();
        key(4'd9); key(4'd9);
        for (int e = 0; e < 37; e++) idle(1'b1);
        check_value("sec99_to_90", dut_digits(), 32'h0090);
        for (int e = 0; e < 4; e++) idle(1'b1);
        check_value("sec90_to_89", dut_digits(), 32'h0089);

        // Pause and resume
        clr_cyc();
        key(4'd3);
        for (int e = 0; e < 6; e++) idle(1'b1);
        check_value("pre_pause", dut_digits(), 32'h0002);
        for (int e = 0; e < 10; e++) begin
            if (e == 4) cyc(1'b1, 4'd7, 1'b0, 1'b1);
            else idle(1'b0);
        end
        check_value("paused", dut_pack(), {13'd0, 2'd2, 1'b0, 16'h0002});
        idle(1'b1);
        check_value("resume", 32'(state), 32'd1);
        idle(1'b1); idle(1'b1);
        check_value("resume_hold", dut_digits(), 32'h0002);
        idle(1'b1);
        check_value("resume_tick", dut_digits(), 32'h0001);

        // Clear during run, zero-time start, digit from DONE
        clr_cyc();
        key(4'd7);
        for (int e = 0; e < 3; e++) idle(1'b1);
        check_value("run_0007", dut_pack(), {13'd0, 2'd1, 1'b0, 16'h0007});
        cyc(1'b0, 4'd0, 1'b1, 1'b0);
        check_value("clear", dut_pack(), 32'd0);
        idle(1'b1);
        check_value("zero_start", dut_pack(), {13'd0, 2'd3, 1'b1, 16'h0000});
        key(4'd4);
        check_value("done_digit", dut_pack(), 32'h0004);

        // Asynchronous reset between edges
        clr_cyc();
        key(4'd7);
        for (int e = 0; e < 3; e++) idle(1'b1);
        #3 resetn = 1'b0;
        #1;
        model_reset();
        check_value("async_reset", dut_pack(), 32'd0);
        resetn = 1'b1;

        // Random traffic
        mag = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) mag = ~mag;
            cyc(($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)), mag,
                ($urandom_range(0, 199) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
